// File: rtl/cnu6_ib_ram_loader.sv
// Copies IB map stage bank sets into the cnu_ib_ram banks: one word per completed set, WORD_NUM words per load.
// Latency: registered outputs, 1 clk after the sampling edge; a full load takes 2*WORD_NUM-1..2*WORD_NUM clks.
// Backpressure: none; writes are paced by map_phase, and load_abort cancels the load at any point.
module cnu6_ib_ram_loader #(
    parameter int QUAN_SIZE = 4,
    parameter int BANK_NUM  = 8,
    parameter int WORD_NUM  = 32,
    parameter int ADDR_W    = 5
) (
    input  logic                            sys_clk,
    input  logic                            rstn,
    input  logic [BANK_NUM*4*QUAN_SIZE-1:0] bank_data,
    input  logic                            map_phase,
    input  logic                            load_start,
    input  logic                            load_abort,
    output logic [BANK_NUM-1:0]             ram_we,
    output logic [ADDR_W-1:0]               ram_waddr,
    output logic [BANK_NUM*4*QUAN_SIZE-1:0] ram_wdata,
    output logic                            busy,
    output logic                            load_done
);

    localparam int DW = BANK_NUM * 4 * QUAN_SIZE;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORD_NUM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] word_cnt, word_cnt_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] waddr_nxt;
    logic [DW-1:0]     wdata_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    // State, word counter and every output are registered together.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            word_cnt  <= '0;
            ram_we    <= '0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            busy      <= 1'b0;
            load_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            word_cnt  <= word_cnt_nxt;
            ram_we    <= {BANK_NUM{we_nxt}};
            ram_waddr <= waddr_nxt;
            ram_wdata <= wdata_nxt;
            busy      <= busy_nxt;
            load_done <= done_nxt;
        end
    end

    // Abort overrides everything, including a start request in IDLE.
    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        if (load_abort) begin
            state_nxt    = IDLE;
            word_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state_nxt    = WRITE;
                        word_cnt_nxt = '0;
                    end
                end
                WRITE: begin
                    if (!map_phase) begin
                        if (word_cnt == LAST_WORD) begin
                            state_nxt    = DONE;
                            word_cnt_nxt = '0;
                        end else begin
                            word_cnt_nxt = word_cnt + 1'b1;
                        end
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // map_phase=0 marks a freshly completed bank set; only then is a word written.
    always_comb begin
        we_nxt    = 1'b0;
        waddr_nxt = ram_waddr;
        wdata_nxt = ram_wdata;
        busy_nxt  = (state_nxt == WRITE);
        done_nxt  = 1'b0;
        if (!load_abort) begin
            case (state)
                WRITE: begin
                    if (!map_phase) begin
                        we_nxt    = 1'b1;
                        waddr_nxt = word_cnt;
                        wdata_nxt = bank_data;
                    end
                end
                DONE:    done_nxt = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cnu6_ib_ram_loader.md
CNU6_IB_RAM_LOADER -- requirements
Module: cnu6_ib_ram_loader

Interface
REQ-001 SHALL have parameter QUAN_SIZE, default 4: bits per IB table entry (one port).
REQ-002 SHALL have parameter BANK_NUM, default 8: number of cnu_ib_ram banks.
REQ-003 SHALL have parameter WORD_NUM, default 32: words written per bank per load.
REQ-004 SHALL have parameter ADDR_W, default 5: RAM write-address width, with 2^ADDR_W >= WORD_NUM.
REQ-005 SHALL have port sys_clk, input, 1: clock; all state updates on posedge.
REQ-006 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port bank_data, input, BANK_NUM*4*QUAN_SIZE: bank k occupies bits [16k+15:16k], ports A..D MSB-first; driven by the IB map stage on negedge.
REQ-008 SHALL have port map_phase, input, 1: IB map stage phase counter; 0 means a complete 8-bank set was updated at the preceding negedge.
REQ-009 SHALL have port load_start, input, 1: single-cycle load request.
REQ-010 SHALL have port load_abort, input, 1: cancel the load in progress.
REQ-011 SHALL have port ram_we, output, BANK_NUM: per-bank write enable.
REQ-012 SHALL have port ram_waddr, output, ADDR_W: write address shared by all banks.
REQ-013 SHALL have port ram_wdata, output, BANK_NUM*4*QUAN_SIZE: registered copy of bank_data, same layout.
REQ-014 SHALL have port busy, output, 1: high in WRITE state.
REQ-015 SHALL have port load_done, output, 1: single-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, DONE, with all outputs registered.
REQ-017 SHALL move IDLE->WRITE on a posedge with load_start=1 and load_abort=0, clearing word_cnt to 0.
REQ-018 SHALL ignore load_start outside IDLE.
REQ-019 SHALL, in WRITE on a posedge with map_phase=0, register ram_we=all-ones, ram_waddr=word_cnt and ram_wdata=bank_data, then increment word_cnt.
REQ-020 SHALL, in WRITE on a posedge with map_phase=1, register ram_we=0 and hold ram_waddr, ram_wdata and word_cnt.
REQ-021 SHALL yield at most one write per two clocks; a full load spans 2*WORD_NUM-1 or 2*WORD_NUM clocks after entering WRITE, depending on the alignment of map_phase.
REQ-022 SHALL move WRITE->DONE on the write with word_cnt=WORD_NUM-1, then wrap word_cnt to 0 (no overflow past WORD_NUM-1).
REQ-023 SHALL, in DONE, register load_done=1 and ram_we=0 for exactly one cycle, then return to IDLE.
REQ-024 SHALL give load_abort=1 priority over all other inputs: next state IDLE, ram_we=0, word_cnt=0, no load_done pulse.
REQ-025 SHALL, when load_start and load_abort are both high in IDLE, remain in IDLE.
REQ-026 SHALL hold ram_we=0 in IDLE and DONE.
REQ-027 SHALL make busy=1 exactly while the state is WRITE.

Reset
REQ-028 SHALL, on rstn=0, asynchronously force state=IDLE, word_cnt=0, ram_we=0, ram_waddr=0, ram_wdata=0, busy=0 and load_done=0.
REQ-029 SHALL, on reset mid-load, discard the partial load; no load_done pulse is produced, and the next load restarts at address 0.

Verification
REQ-030 SHALL verify a nominal load: WORD_NUM=32, map_phase toggling, load_start pulse -> 32 writes at addresses 0..31, each with ram_we=8'hFF and ram_wdata matching bank_data sampled at that edge; then one load_done pulse; busy low afterwards.
REQ-031 SHALL verify phase gating: map_phase held at 1 for 10 cycles during WRITE -> ram_we=0, and ram_waddr/word_cnt frozen for those cycles.
REQ-032 SHALL verify abort: load_abort after the write to address 12 -> IDLE next cycle, no further writes, no load_done; the next load_start writes from address 0.
REQ-033 SHALL verify async reset: rstn low mid-WRITE between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
REQ-034 SHALL verify start rules: load_start during WRITE -> ignored, with exactly 32 writes and a single load_done; load_start together with load_abort in IDLE -> stays IDLE.
